// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: frame geometry and FSM state encoding,
//               used by both the transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Baud divider. Counts 0..CLKS_PER_BIT-1 and flags the wrap
//               cycle with a one-cycle tick (a bit boundary). A clear restarts
//               the count so a new frame begins on a full bit time.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Free-running bit-time counter, restarted by clear or on reaching the last count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx
// Description : 8051 mode-1 UART transmitter. A write to SBUF while idle sends
//               a 10-bit frame (start, 8 data LSB first, stop) on txd and sets
//               the sticky TI flag at the start of the stop bit.
//               All outputs are registered and follow the FSM by one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sbuf_wr,
    input  logic [7:0] sbuf_din,
    input  logic       ti_clr,
    output logic       txd,
    output logic       ti,
    output logic       busy
);

    import uart_pkg::*;

    localparam int c_idx_w = $clog2(DATA_BITS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [DATA_BITS-1:0] r_shreg;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic                 w_tick;
    logic                 w_accept;
    logic                 w_enter_stop;
    logic                 w_line;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_ti;
    logic                 r_ti_set;

    // The state check closes the one-cycle window where busy still shows idle
    // although a write has just been taken.
    assign w_accept = sbuf_wr && !r_busy && (r_state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(w_accept),
        .tick (w_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, stop-entry detect and line level for the current state
    always_comb begin
        w_state_next = r_state;
        w_enter_stop = 1'b0;
        w_line       = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_line = 1'b0;
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_line = r_shreg[0];
                if (w_tick && (r_bit_idx == c_last_idx)) begin
                    w_state_next = STOP;
                    w_enter_stop = 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Shift register and bit index: load on accept, shift at each data-bit boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
        end else if (w_accept) begin
            r_shreg   <= sbuf_din;
            r_bit_idx <= '0;
        end else if ((r_state == DATA) && w_tick) begin
            r_shreg   <= {1'b0, r_shreg[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    // Registered outputs; TI set takes priority over a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
            r_ti_set <= 1'b0;
            r_ti     <= 1'b0;
        end else begin
            r_txd    <= w_line;
            r_busy   <= (r_state != IDLE);
            r_ti_set <= w_enter_stop;
            if (r_ti_set) begin
                r_ti <= 1'b1;
            end else if (ti_clr) begin
                r_ti <= 1'b0;
            end
        end
    end

    assign txd  = r_txd;
    assign busy = r_busy;
    assign ti   = r_ti;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx
// Description : Directed self-checking bench for serial_tx at 4 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    import uart_pkg::*;

    localparam int CPB = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       sbuf_wr  = 1'b0;
    logic [7:0] sbuf_din = 8'h00;
    logic       ti_clr   = 1'b0;
    logic       txd;
    logic       ti;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    serial_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sbuf_wr (sbuf_wr),
        .sbuf_din(sbuf_din),
        .ti_clr  (ti_clr),
        .txd     (txd),
        .ti      (ti),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle write; returns #1 after the sampling edge (edge N)
    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        sbuf_din = b;
        sbuf_wr  = 1'b1;
        @(posedge clk);
        #1;
        sbuf_wr = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ti_clr = 1'b1;
        @(posedge clk);
        #1;
        ti_clr = 1'b0;
    endtask

    // Called just after edge N; checks edges N+1 .. N+41. Optional extra write
    // (wr_i) and ti_clr (clr_i) are sampled at edge N+1+index.
    task automatic run_frame(input string name, input logic [7:0] b, input logic ti_before,
                             input int wr_i, input logic [7:0] wr_b, input int clr_i);
        logic [FRAME_BITS-1:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i <= FRAME_BITS * CPB; i++) begin
            if (i == wr_i) begin
                sbuf_din = wr_b;
                sbuf_wr  = 1'b1;
            end
            if (i == clr_i) begin
                ti_clr = 1'b1;
            end
            @(posedge clk);
            #1;
            sbuf_wr = 1'b0;
            ti_clr  = 1'b0;
            chk($sformatf("%s_txd_%0d", name, i), txd,
                (i < FRAME_BITS * CPB) ? frame[i / CPB] : 1'b1);
            chk($sformatf("%s_busy_%0d", name, i), busy, (i < FRAME_BITS * CPB));
            chk($sformatf("%s_ti_%0d", name, i), ti, ti_before || (i >= 9 * CPB));
        end
    endtask

    initial begin
        // Reset values
        rst = 1'b0;
        #200;
        chk("rst_txd", txd, 1'b1);
        chk("rst_ti", ti, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Idle line for 100 cycles
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("idle_txd_%0d", i), txd, 1'b1);
            chk($sformatf("idle_ti_%0d", i), ti, 1'b0);
            chk($sformatf("idle_busy_%0d", i), busy, 1'b0);
        end

        // Single frame 0xA5
        write_byte(8'hA5);
        chk("t1_busy_edgeN", busy, 1'b0);
        chk("t1_txd_edgeN", txd, 1'b1);
        run_frame("t1", 8'hA5, 1'b0, -1, 8'h00, -1);
        pulse_clr();
        chk("t1_ti_cleared", ti, 1'b0);
        pulse_clr();
        chk("t1_clr_when_zero", ti, 1'b0);

        // Write while busy (0xFF at N+10) is ignored
        write_byte(8'h3C);
        run_frame("t2", 8'h3C, 1'b0, 9, 8'hFF, -1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("t2_after_txd_%0d", i), txd, 1'b1);
            chk($sformatf("t2_after_busy_%0d", i), busy, 1'b0);
            chk($sformatf("t2_after_ti_%0d", i), ti, 1'b1);
        end
        pulse_clr();
        chk("t2_ti_cleared", ti, 1'b0);

        // Back-to-back: write in last stop cycle dropped, write when busy drops accepted
        write_byte(8'h00);
        run_frame("t3a", 8'h00, 1'b0, 40, 8'hF0, -1);
        write_byte(8'h81);
        run_frame("t3b", 8'h81, 1'b1, -1, 8'h00, -1);
        pulse_clr();
        chk("t3_ti_cleared", ti, 1'b0);

        // TI clear colliding with set: set wins
        write_byte(8'h5A);
        run_frame("t4", 8'h5A, 1'b0, -1, 8'h00, 9 * CPB);
        step();
        chk("t4_ti_held", ti, 1'b1);
        pulse_clr();
        chk("t4_ti_cleared", ti, 1'b0);

        // Reset mid-frame during data bit 2, then a clean frame
        write_byte(8'hC3);
        repeat (14) step();
        chk("t5_txd_bit2", txd, 1'b0);
        chk("t5_busy_mid", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_txd", txd, 1'b1);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ti", ti, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("t5_post_txd", txd, 1'b1);
        chk("t5_post_ti", ti, 1'b0);
        write_byte(8'h55);
        run_frame("t5", 8'h55, 1'b0, -1, 8'h00, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
